// File: rtl/level_fifo.sv
// level_fifo: FWFT valid/ready FIFO with occupancy count, level flags, flush and high watermark.
module level_fifo #(
  parameter int WIDTH         = 32,
  parameter int ADDR_W        = 10,
  parameter int AFULL_THRESH  = 2**ADDR_W - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              flush,
  input  logic              i_val,
  output logic              i_rdy,
  input  logic [WIDTH-1:0]  i_data,
  output logic              o_val,
  input  logic              o_rdy,
  output logic [WIDTH-1:0]  o_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_afull,
  output logic              o_aempty,
  output logic [ADDR_W:0]   o_max_lvl
);
  localparam int CAP = 2**ADDR_W;
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CAP - 2);
  logic [WIDTH-1:0] mem_q [CAP-1];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, max_q, max_d, ram_cnt;
  logic out_val_q, out_val_d, afull_q, afull_d, aempty_q, aempty_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic push, pop, load, ram_nz, bypass, ram_we;
  assign i_rdy = srst_n & ~flush & (count_q < CW'(CAP));
  assign o_val = out_val_q;
  assign o_data = out_data_q;
  assign o_count = count_q;
  assign o_afull = afull_q;
  assign o_aempty = aempty_q;
  assign o_max_lvl = max_q;
  always_comb begin
    push = i_val & i_rdy;
    pop = out_val_q & o_rdy;
    ram_cnt = count_q - CW'(out_val_q);
    ram_nz = ram_cnt != '0;
    load = ~out_val_q | pop;
    bypass = push & load & ~ram_nz;
    ram_we = push & ~bypass;
    wr_ptr_d = flush ? '0 : ram_we ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : (load & ram_nz) ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    out_val_d = ~flush & (load ? (ram_nz | push) : 1'b1);
    out_data_d = ~load ? out_data_q : ram_nz ? mem_q[rd_ptr_q] : i_data;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    afull_d = count_d >= CW'(AFULL_THRESH);
    aempty_d = count_d <= CW'(AEMPTY_THRESH);
    max_d = flush ? '0 : (count_d > max_q ? count_d : max_q);
  end
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      max_q <= '0;
      out_val_q <= 1'b0;
      afull_q <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      max_q <= max_d;
      out_val_q <= out_val_d;
      afull_q <= afull_d;
      aempty_q <= aempty_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[wr_ptr_q] <= i_data;
    out_data_q <= out_data_d;
  end
endmodule

// File: tb/tb_level_fifo.sv
// tb_level_fifo: randomized queue-model check of level_fifo at ADDR_W=4.
module tb_level_fifo;
  localparam int CAP = 16;
  localparam int AF = 12;
  localparam int AE = 4;
  logic clk = 0, srst_n = 0, flush = 0, i_val = 0, o_rdy = 0;
  logic [31:0] i_data = 0;
  logic i_rdy, o_val, o_afull, o_aempty;
  logic [31:0] o_data;
  logic [4:0] o_count, o_max_lvl;
  int checks = 0, errors = 0;
  int mmax = 0;
  bit armed = 0;
  logic [31:0] q[$];
  always #5 clk = ~clk;
  level_fifo #(.WIDTH(32), .ADDR_W(4), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clk(clk), .srst_n(srst_n), .flush(flush), .i_val(i_val), .i_rdy(i_rdy),
    .i_data(i_data), .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data),
    .o_count(o_count), .o_afull(o_afull), .o_aempty(o_aempty), .o_max_lvl(o_max_lvl)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic r, input logic f, input logic rn, input logic [31:0] d);
    logic m_rdy, mpush, mpop;
    @(negedge clk);
    i_val = v; o_rdy = r; flush = f; srst_n = rn; i_data = d;
    #1;
    m_rdy = rn & ~f & (q.size() < CAP);
    if (armed) begin
      check("i_rdy", 32'(i_rdy), 32'(m_rdy));
      check("o_val", 32'(o_val), 32'(q.size() > 0));
      if (q.size() > 0) check("o_data", o_data, q[0]);
      check("o_count", 32'(o_count), 32'(q.size()));
      check("o_afull", 32'(o_afull), 32'(q.size() >= AF));
      check("o_aempty", 32'(o_aempty), 32'(q.size() <= AE));
      check("o_max_lvl", 32'(o_max_lvl), 32'(mmax));
    end
    @(posedge clk);
    mpush = v & m_rdy;
    mpop = (q.size() > 0) & r;
    if (!rn) begin
      q.delete();
      mmax = 0;
      armed = 1;
    end else begin
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(d);
      if (f) q.delete();
      mmax = f ? 0 : (q.size() > mmax ? q.size() : mmax);
    end
  endtask
  initial begin
    int pv, pr;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'hdead);
    step(1, 0, 0, 1, 32'h100);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 1, i);
    for (int i = 0; i < 18; i++) step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, 32'hA5A5A5A5);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 32'h200 + i);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1, 32'h300 + i);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 32'h400 + i);
    step(1, 1, 1, 1, 32'h4ff);
    step(1, 0, 0, 1, 32'h500);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 32'h600 + i);
    step(1, 1, 0, 0, 32'h6ff);
    step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, 32'h700);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
    for (int k = 0; k < 10000; k++) begin
      pv = (k / 500) % 3;
      pr = (k / 700) % 3;
      step($urandom_range(0, 3) < 3 - pv ? 1'b1 : 1'b0,
           $urandom_range(0, 3) < 1 + pr ? 1'b1 : 1'b0,
           $urandom_range(0, 299) == 0 ? 1'b1 : 1'b0,
           $urandom_range(0, 999) != 0 ? 1'b1 : 1'b0,
           $urandom);
    end
    step(0, 0, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
